// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide issue path.
//   - md_op_e    : 4-bit op class carried by the D and E pipeline stages
//   - md_ctr_e   : 3-bit operation code presented to the multiply/divide unit
//   - md_state_e : issue controller FSM states
// The multiply/divide unit imports this package too, so both sides always
// agree on the md_ctr codes.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [2:0] {
    CTR_MULT  = 3'b000,
    CTR_MULTU = 3'b001,
    CTR_DIV   = 3'b010,
    CTR_DIVU  = 3'b011,
    CTR_MTHI  = 3'b100,
    CTR_MTLO  = 3'b101,
    CTR_IDLE  = 3'b111
  } md_ctr_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Raw codes 9..15 are not md instructions; fold them onto OP_NONE.
  function automatic md_op_e md_op_decode(input logic [3:0] raw);
    if (raw <= 4'd8) begin
      return md_op_e'(raw);
    end else begin
      return OP_NONE;
    end
  endfunction

  // MULT/MULTU/DIV/DIVU: operations that occupy the unit for LAT cycles.
  function automatic logic md_is_arith(input md_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Any op that writes HI/LO (arith or MTHI/MTLO).
  function automatic logic md_is_writer(input md_op_e op);
    return md_is_arith(op) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Any op that touches HI/LO at all (writers plus MFHI/MFLO).
  function automatic logic md_is_md(input md_op_e op);
    return md_is_writer(op) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// md_lat_counter: 4-bit latency down-counter for the md issue controller.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load_i          : load load_val_i (takes priority over dec_i)
//   load_val_i      : value loaded on load_i
//   dec_i           : decrement by one (saturates at zero)
//   zero_o          : counter currently holds zero
module md_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  // Counter register: reset, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues mult/div operations from the E stage to the
// multiply/divide unit, tracks the busy window and stalls D/F for HI/LO
// dependent instructions.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   e_valid      : E-stage instruction valid
//   e_op         : md op class of the E-stage instruction
//   e_flush      : E-stage instruction killed this cycle
//   d_op         : md op class of the D-stage instruction
//   md_start     : start pulse to the md unit (same cycle as issue)
//   md_ctr       : operation code to the md unit (111 when idle)
//   stall_d      : hold D and F
//   md_busy      : operation in flight
//   md_done      : last busy cycle
//   proto_err    : sticky, md write op seen in E while busy
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [3:0] e_op,
  input  logic       e_flush,
  input  logic [3:0] d_op,
  output logic       md_start,
  output logic [2:0] md_ctr,
  output logic       stall_d,
  output logic       md_busy,
  output logic       md_done,
  output logic       proto_err
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT - 1);

  md_state_e state_q, state_d;
  md_op_e    e_cls_s, d_cls_s;
  logic      issue_s, hilo_wr_s, proto_s;
  logic      load_s, dec_s, zero_s;
  logic [3:0] load_val_s;
  logic [2:0] ctr_s;
  logic      start_s;
  logic      proto_err_q, proto_err_d;

  assign e_cls_s = md_op_decode(e_op);
  assign d_cls_s = md_op_decode(d_op);

  // Reset is folded in here so it wins over a same-cycle issue.
  assign issue_s   = !reset && e_valid && !e_flush && md_is_arith(e_cls_s) && (state_q == ST_IDLE);
  assign hilo_wr_s = !reset && e_valid && !e_flush &&
                     ((e_cls_s == OP_MTHI) || (e_cls_s == OP_MTLO)) && (state_q == ST_IDLE);
  assign proto_s   = !reset && e_valid && md_is_writer(e_cls_s) && (state_q == ST_RUN);

  assign load_val_s = ((e_cls_s == OP_MULT) || (e_cls_s == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;

  md_lat_counter u_lat (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .dec_i      (dec_s),
    .zero_o     (zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control and md unit command.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    dec_s   = 1'b0;
    start_s = 1'b0;
    ctr_s   = CTR_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          start_s = 1'b1;
          ctr_s   = 3'(e_op - 4'd1);
          load_s  = 1'b1;
          state_d = ST_RUN;
        end else if (hilo_wr_s) begin
          ctr_s = (e_cls_s == OP_MTHI) ? CTR_MTHI : CTR_MTLO;
        end else begin
          ctr_s = CTR_IDLE;
        end
      end
      ST_RUN: begin
        // Flush does not affect an operation already running.
        dec_s = 1'b1;
        if (zero_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err_d = proto_err_q | proto_s;

  assign md_start  = start_s;
  assign md_ctr    = ctr_s;
  assign md_busy   = !reset && (state_q == ST_RUN);
  // A reset landing on the final cycle must not produce a done pulse.
  assign md_done   = md_busy && zero_s;
  // The done cycle releases D so the dependent op reaches E with the FSM idle.
  assign stall_d   = !reset && md_is_md(d_cls_s) && (issue_s || (md_busy && !md_done));
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       e_valid;
  logic [3:0] e_op;
  logic       e_flush;
  logic [3:0] d_op;
  logic       md_start;
  logic [2:0] md_ctr;
  logic       stall_d;
  logic       md_busy;
  logic       md_done;
  logic       proto_err;

  int checks;
  int errors;

  typedef struct {
    string      tag;
    logic       start;
    logic [2:0] ctr;
    logic       busy;
    logic       done;
    logic       stall;
    logic       perr;
  } exp_t;

  exp_t sb_q[$];

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_flush   (e_flush),
    .d_op      (d_op),
    .md_start  (md_start),
    .md_ctr    (md_ctr),
    .stall_d   (stall_d),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs, push expectation, compare at the falling edge,
  // then move to just after the next rising edge.
  task automatic cyc(input string tag, input logic rst, input logic ev,
                     input logic [3:0] op, input logic fl, input logic [3:0] dop,
                     input logic x_start, input logic [2:0] x_ctr, input logic x_busy,
                     input logic x_done, input logic x_stall, input logic x_perr);
    exp_t e;
    exp_t g;
    reset   = rst;
    e_valid = ev;
    e_op    = op;
    e_flush = fl;
    d_op    = dop;
    e.tag = tag; e.start = x_start; e.ctr = x_ctr; e.busy = x_busy;
    e.done = x_done; e.stall = x_stall; e.perr = x_perr;
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    checks++;
    assert (md_start === g.start) else begin errors++; $error("FAIL %s md_start got %b exp %b", g.tag, md_start, g.start); end
    checks++;
    assert (md_ctr === g.ctr) else begin errors++; $error("FAIL %s md_ctr got %b exp %b", g.tag, md_ctr, g.ctr); end
    checks++;
    assert (md_busy === g.busy) else begin errors++; $error("FAIL %s md_busy got %b exp %b", g.tag, md_busy, g.busy); end
    checks++;
    assert (md_done === g.done) else begin errors++; $error("FAIL %s md_done got %b exp %b", g.tag, md_done, g.done); end
    checks++;
    assert (stall_d === g.stall) else begin errors++; $error("FAIL %s stall_d got %b exp %b", g.tag, stall_d, g.stall); end
    checks++;
    assert (proto_err === g.perr) else begin errors++; $error("FAIL %s proto_err got %b exp %b", g.tag, proto_err, g.perr); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; e_valid = 1'b0; e_op = 4'd0; e_flush = 1'b0; d_op = 4'd0;
    @(posedge clk);
    #1;

    // Reset beats a same-cycle MULT issue; outputs sit at reset values.
    cyc("rst_issue", 1'b1, 1'b1, 4'd1, 1'b0, 4'd8, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post_rst",  1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);

    // MULT at t: start/000 at t, busy t+1..t+5, done at t+5, idle at t+6.
    cyc("mult_iss",  1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++)
      cyc("mult_busy", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mult_done", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("mult_idle", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);

    // DIVU at t with MFLO in D: stall t..t+9, released in done cycle t+10,
    // MFLO reaches E at t+11 with the unit idle.
    cyc("divu_iss",  1'b0, 1'b1, 4'd4, 1'b0, 4'd8, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++)
      cyc("divu_stall", 1'b0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("divu_done", 1'b0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("mflo_in_e", 1'b0, 1'b1, 4'd8, 1'b0, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flushed MULTU issues nothing.
    cyc("multu_fl",  1'b0, 1'b1, 4'd2, 1'b1, 4'd7, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("multu_fl2", 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);

    // DIV at t, flush at t+2 does not abort; done at t+10. D-stage non-md ops
    // (including out-of-range code 9) are not stalled while busy.
    cyc("div_iss",   1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("div_b1",    1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("div_flush", 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("div_dmtlo", 1'b0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i <= 9; i++)
      cyc("div_busy", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("div_done",  1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("div_idle",  1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-MULT: operation abandoned, no done pulse.
    cyc("rmult_iss", 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rmult_b1",  1'b0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rmult_b2",  1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rmult_rst", 1'b1, 1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 4; i <= 6; i++)
      cyc("rmult_after", 1'b0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);

    // MTHI during RUN: protocol error (sticky), nothing issued.
    cyc("pe_iss",    1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("pe_mthi",   1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++)
      cyc("pe_sticky", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("pe_done",   1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("mthi_idle", 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("mthi_gone", 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("mtlo_idle", 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("mtlo_fl",   1'b0, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("op12_none", 1'b0, 1'b1, 4'd12, 1'b0, 4'd12, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("rst_clr",   1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("perr_clr",  1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
